// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit and the decoder that drives it.
// Holds the operation codes, HI/LO move codes and the FSM state encoding.
package mdu_pkg;

   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULTS = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIVS  = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;

   localparam logic [1:0] MW_NONE  = 2'd0;
   localparam logic [1:0] MW_HI    = 2'd1;
   localparam logic [1:0] MW_LO    = 2'd2;

   localparam int CNT_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mdu_state_e;

   function automatic logic is_md_op(input logic [2:0] op);
      return (op >= MD_MULTS) && (op <= MD_DIVU);
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == MD_DIVS) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mdu_result_calc.sv
// Combinational 64-bit multiply / divide result generator.
// Produces {hi,lo} for the requested operation and flags a zero divisor.
module mdu_result_calc
   import mdu_pkg::*;
(
   input  logic [2:0]  i_mdcal,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [63:0] o_result,
   output logic        o_div_by_zero
);

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return (~v) + 32'd1;
   endfunction

   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? neg32(v) : v;
   endfunction

   logic signed [63:0] w_sa64;
   logic signed [63:0] w_sb64;
   logic signed [63:0] w_prod_s;
   logic        [63:0] w_prod_u;
   logic               w_b_zero;
   logic        [31:0] w_mag_a;
   logic        [31:0] w_mag_b;
   logic        [31:0] w_sdiv_b;
   logic        [31:0] w_udiv_b;
   logic        [31:0] w_qmag;
   logic        [31:0] w_rmag;
   logic        [31:0] w_quo_s;
   logic        [31:0] w_rem_s;
   logic        [31:0] w_quo_u;
   logic        [31:0] w_rem_u;

   assign w_sa64   = {{32{i_a[31]}}, i_a};
   assign w_sb64   = {{32{i_b[31]}}, i_b};
   assign w_prod_s = w_sa64 * w_sb64;
   assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

   // Divisors are forced to 1 when zero so the dividers never see a zero operand.
   assign w_b_zero = (i_b == 32'd0);
   assign w_mag_a  = abs32(i_a);
   assign w_mag_b  = abs32(i_b);
   assign w_sdiv_b = w_b_zero ? 32'd1 : w_mag_b;
   assign w_udiv_b = w_b_zero ? 32'd1 : i_b;

   // Magnitude division: 0x80000000 / -1 yields magnitude 2^31, which re-negates to 0x80000000 with remainder 0.
   assign w_qmag   = w_mag_a / w_sdiv_b;
   assign w_rmag   = w_mag_a % w_sdiv_b;
   assign w_quo_s  = (i_a[31] ^ i_b[31]) ? neg32(w_qmag) : w_qmag;
   assign w_rem_s  = i_a[31] ? neg32(w_rmag) : w_rmag;
   assign w_quo_u  = i_a / w_udiv_b;
   assign w_rem_u  = i_a % w_udiv_b;

   always_comb begin
      o_result      = 64'd0;
      o_div_by_zero = 1'b0;
      case (i_mdcal)
         MD_MULTS: o_result = w_prod_s;
         MD_MULTU: o_result = w_prod_u;
         MD_DIVS: begin
            o_div_by_zero = w_b_zero;
            if (!w_b_zero) o_result = {w_rem_s, w_quo_s};
         end
         MD_DIVU: begin
            o_div_by_zero = w_b_zero;
            if (!w_b_zero) o_result = {w_rem_u, w_quo_u};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mul_div_unit.sv
// Execute-stage multiply/divide unit owning the HI/LO registers.
// Results are computed at issue and committed after a fixed busy latency.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  MDcal,
   input  logic [1:0]  MDWrite,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

   mdu_state_e       r_state;
   mdu_state_e       w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [63:0]      r_pend;
   logic             r_pend_dbz;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;
   logic [63:0]      w_result;
   logic             w_div_by_zero;
   logic             w_start_ok;
   logic             w_done;
   logic             w_busy;

   mdu_result_calc u_calc (
      .i_mdcal       (MDcal),
      .i_a           (A),
      .i_b           (B),
      .o_result      (w_result),
      .o_div_by_zero (w_div_by_zero)
   );

   assign w_start_ok = (r_state == IDLE) && start && is_md_op(MDcal);
   assign w_done     = (r_state == BUSY) && (r_cnt <= 4'd1);

   always_ff @(posedge clk) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_start_ok) w_next_state = BUSY;
         BUSY:    if (w_done)     w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      w_busy = 1'b0;
      if (r_state == BUSY) w_busy = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt      <= '0;
         r_pend     <= 64'd0;
         r_pend_dbz <= 1'b0;
      end else if (w_start_ok) begin
         r_cnt      <= is_div_op(MDcal) ? DIV_LOAD : MULT_LOAD;
         r_pend     <= w_result;
         r_pend_dbz <= w_div_by_zero;
      end else if (r_state == BUSY) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // Moves are honoured only in IDLE and only when no operation is issued the same cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_hi <= 32'd0;
         r_lo <= 32'd0;
      end else if (w_done) begin
         if (!r_pend_dbz) begin
            r_hi <= r_pend[63:32];
            r_lo <= r_pend[31:0];
         end
      end else if ((r_state == IDLE) && !w_start_ok) begin
         if (MDWrite == MW_HI) r_hi <= A;
         if (MDWrite == MW_LO) r_lo <= A;
      end
   end

   assign busy = w_busy;
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized self-checking bench for mul_div_unit against a plain-arithmetic model.
// The model tracks architectural HI/LO and computes results with 64-bit integer math.
module tb_mul_div_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  MDcal;
   logic [1:0]  MDWrite;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int n_total = 0;
   int n_bad   = 0;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .MDcal   (MDcal),
      .MDWrite (MDWrite),
      .A       (A),
      .B       (B),
      .busy    (busy),
      .HI      (HI),
      .LO      (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_regs(input string tag);
      check_val({tag, " HI"}, {32'd0, HI}, {32'd0, m_hi});
      check_val({tag, " LO"}, {32'd0, LO}, {32'd0, m_lo});
   endtask

   // Reference: returns {div_by_zero, hi, lo}
   function automatic logic [64:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd1: begin p = 64'(sa * sb); return {1'b0, p}; end
         3'd2: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
         3'd3: begin
            if (b == 0) return {1'b1, 64'd0};
            q = sa / sb;
            r = sa % sb;
            return {1'b0, r[31:0], q[31:0]};
         end
         3'd4: begin
            if (b == 0) return {1'b1, 64'd0};
            return {1'b0, a % b, a / b};
         end
         default: return {1'b1, 64'd0};
      endcase
   endfunction

   task automatic mdwrite(input logic [1:0] code, input logic [31:0] val);
      MDWrite = code;
      A       = val;
      tick();
      MDWrite = 2'd0;
      if (code == 2'd1) m_hi = val;
      if (code == 2'd2) m_lo = val;
      check_regs("mdwrite");
      check_val("mdwrite busy", {63'd0, busy}, 64'd0);
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit disturb);
      logic [64:0] exp;
      int n;
      exp = ref_op(op, a, b);
      n = (op <= 3'd2) ? 5 : 10;
      MDcal = op;
      A     = a;
      B     = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      MDcal = 3'd0;
      for (int i = 0; i < n; i++) begin
         check_val({tag, " busy"}, {63'd0, busy}, 64'd1);
         check_val({tag, " hold"}, {HI, LO}, {m_hi, m_lo});
         if (disturb && i == 1) begin
            start   = 1'b1;
            MDcal   = 3'($urandom_range(1, 4));
            A       = $urandom;
            B       = $urandom;
            MDWrite = 2'd2;
         end
         tick();
         start   = 1'b0;
         MDcal   = 3'd0;
         MDWrite = 2'd0;
      end
      if (!exp[64]) begin
         m_hi = exp[63:32];
         m_lo = exp[31:0];
      end
      check_val({tag, " done"}, {63'd0, busy}, 64'd0);
      check_regs(tag);
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] ra, rb;
      reset   = 1'b0;
      start   = 1'b0;
      MDcal   = 3'd0;
      MDWrite = 2'd0;
      A       = 32'd0;
      B       = 32'd0;
      m_hi    = 32'd0;
      m_lo    = 32'd0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      check_val("reset busy", {63'd0, busy}, 64'd0);
      check_regs("reset");

      run_op("smul", 3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
      check_val("smul value", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);
      run_op("umul", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      check_val("umul value", {HI, LO}, 64'hFFFFFFFE_00000001);
      run_op("sdiv", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
      check_val("sdiv value", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
      run_op("ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      check_val("ovf value", {HI, LO}, 64'h00000000_80000000);

      mdwrite(2'd1, 32'h11);
      mdwrite(2'd2, 32'h22);
      run_op("dbz", 3'd4, 32'h1234, 32'd0, 1'b0);
      check_val("dbz value", {HI, LO}, 64'h00000011_00000022);
      mdwrite(2'd1, 32'hDEADBEEF);
      check_val("mthi value", {32'd0, HI}, 64'hDEADBEEF);
      mdwrite(2'd3, 32'h55555555);

      run_op("disturb", 3'd4, 32'd1000, 32'd7, 1'b1);
      check_val("disturb value", {HI, LO}, {32'd6, 32'd142});

      MDcal = 3'd5;
      start = 1'b1;
      A     = 32'h99;
      tick();
      check_val("badop busy", {63'd0, busy}, 64'd0);
      MDcal = 3'd0;
      tick();
      start = 1'b0;
      check_val("noop busy", {63'd0, busy}, 64'd0);
      check_regs("badop");

      for (int k = 0; k < 40; k++) begin
         op = 3'($urandom_range(1, 4));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 9));
            2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            3: rb = -32'($urandom_range(1, 9));
            default: ;
         endcase
         run_op("rand", op, ra, rb, bit'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) mdwrite(2'($urandom_range(0, 3)), $urandom);
      end

      mdwrite(2'd1, 32'hAAAA0000);
      MDcal = 3'd1;
      A     = 32'h1234;
      B     = 32'h5678;
      start = 1'b1;
      tick();
      start = 1'b0;
      MDcal = 3'd0;
      tick();
      tick();
      check_val("midrst busy", {63'd0, busy}, 64'd1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      m_hi = 32'd0;
      m_lo = 32'd0;
      check_val("midrst busy0", {63'd0, busy}, 64'd0);
      check_regs("midrst");
      for (int i = 0; i < 6; i++) tick();
      check_val("midrst after busy", {63'd0, busy}, 64'd0);
      check_regs("midrst after");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
